// File: rtl/slew_dac_spi_pkg.sv
// Shared definitions for the slewed-value DAC SPI feeder: command nibble,
// word field widths and the transfer engine state encoding.
package slew_dac_spi_pkg;

  localparam logic [3:0] SPI_CMD      = 4'b0011;
  localparam int         CMD_W        = 4;
  localparam int         ADDR_FIELD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

endpackage

// File: rtl/slew_dac_spi_word_shift.sv
// Mode-0 SPI word engine: SETUP / SHIFT / HOLD sequencing of one cw-bit word,
// MSB first, with each sclk phase lasting div clk cycles.
module spi_word_shift
  import slew_dac_spi_pkg::*;
#(
  parameter int cw  = 16,
  parameter int div = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [cw-1:0] word_i,
  output logic          sclk_o,
  output logic          csb_o,
  output logic          sdo_o,
  output logic          done_o,
  output logic [1:0]    state_o
);

  localparam int DCW = (div > 1) ? $clog2(div) : 1;
  localparam int BCW = (cw > 1) ? $clog2(cw) : 1;

  spi_state_e     state_q, state_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic           phase_q, phase_d;
  logic [cw-1:0]  sreg_q, sreg_d;
  logic           div_end;

  assign div_end = (cnt_q == DCW'(div - 1));

  // phase_q=1 is the sclk-high half of a bit period; the shift happens as
  // that half ends so the next bit appears on the falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    sreg_d  = sreg_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        if (start_i) begin
          sreg_d  = word_i;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_end) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BCW'(cw - 1)) begin
              state_d = ST_HOLD;
            end else begin
              bit_d  = bit_q + BCW'(1);
              sreg_d = {sreg_q[cw-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      ST_HOLD: begin
        if (div_end) begin
          cnt_d   = '0;
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      sreg_q  <= sreg_d;
    end
  end

  assign csb_o   = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
  assign sclk_o  = (state_q == ST_SHIFT) && phase_q;
  assign sdo_o   = csb_o ? 1'b0 : sreg_q[cw-1];
  assign state_o = state_q;

endmodule

// File: rtl/slew_dac_spi.sv
// Shadow bank + dirty flags for slewed channel values; changed channels are
// picked round-robin and sent to the DAC one SPI word at a time.
module slew_dac_spi
  import slew_dac_spi_pkg::*;
#(
  parameter int aw  = 2,
  parameter int dw  = 5,
  parameter int cw  = 16,
  parameter int div = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [aw-1:0] in_addr,
  input  logic [dw-1:0] in_data,
  output logic          sclk,
  output logic          csb,
  output logic          sdo,
  output logic          busy,
  output logic          overrun
);

  localparam int NCH = 1 << aw;
  localparam int DFW = cw - CMD_W - ADDR_FIELD_W;

  logic [dw-1:0]           shadow_q [NCH];
  logic [NCH-1:0]          dirty_q, dirty_d;
  logic [aw-1:0]           ptr_q, ptr_d;
  logic                    overrun_q, overrun_d;
  logic [aw-1:0]           scan_idx, sel;
  logic                    found, load;
  logic [ADDR_FIELD_W-1:0] addr_field;
  logic [DFW-1:0]          data_field;
  logic [cw-1:0]           word;
  logic [1:0]              eng_state;
  logic                    done_w;

  assign busy = (eng_state != ST_IDLE);

  // First dirty channel at or after ptr, wrapping. Only registered dirty
  // bits are looked at, so a write lands in the scan one cycle later.
  always_comb begin
    found    = 1'b0;
    sel      = ptr_q;
    scan_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      scan_idx = ptr_q + aw'(i);
      if (!found && dirty_q[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  assign load = found && !busy;

  always_comb begin
    addr_field          = '0;
    addr_field[aw-1:0]  = sel;
    data_field          = DFW'($signed(shadow_q[sel]));
    word                = {SPI_CMD, addr_field, data_field};
  end

  // A write to the channel being loaded keeps it dirty so it goes out again.
  always_comb begin
    dirty_d   = dirty_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    if (load) begin
      dirty_d[sel] = 1'b0;
      ptr_d        = sel + aw'(1);
    end
    if (in_valid) begin
      dirty_d[in_addr] = 1'b1;
      if (dirty_q[in_addr]) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_q   <= '0;
      ptr_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else begin
      dirty_q   <= dirty_d;
      ptr_q     <= ptr_d;
      overrun_q <= overrun_d;
      if (in_valid) shadow_q[in_addr] <= in_data;
    end
  end

  assign overrun = overrun_q;

  spi_word_shift #(
    .cw  (cw),
    .div (div)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start_i (load),
    .word_i  (word),
    .sclk_o  (sclk),
    .csb_o   (csb),
    .sdo_o   (sdo),
    .done_o  (done_w),
    .state_o (eng_state)
  );

  // The engine only reports completion from its HOLD phase.
  always_ff @(posedge clk) begin
    if (!rst && done_w) assert (eng_state == ST_HOLD);
  end

endmodule

// File: tb/tb_slew_dac_spi.sv
// Directed bench for slew_dac_spi: decodes SPI frames from the pins and
// compares them with hand-computed words and frame timing.
module tb_slew_dac_spi;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_addr;
  logic [4:0] in_data;
  logic       sclk, csb, sdo, busy, overrun;

  int checks   = 0;
  int failures = 0;

  slew_dac_spi #(.aw(2), .dw(5), .cw(16), .div(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .sclk     (sclk),
    .csb      (csb),
    .sdo      (sdo),
    .busy     (busy),
    .overrun  (overrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // pin-level frame monitor, sampling on the falling clk edge
  logic [15:0] word_q[$];
  int          low_q[$];
  int          rise_q[$];
  int          busy_q[$];
  logic [15:0] cur_word;
  int          cur_rises = 0;
  int          cur_low   = 0;
  int          busy_run  = 0;
  int          mode_err  = 0;
  logic        prev_csb  = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_sdo  = 1'b0;

  always @(negedge clk) begin
    if (csb === 1'b0) begin
      if (prev_csb) begin
        cur_word  = '0;
        cur_rises = 0;
        cur_low   = 0;
      end
      cur_low++;
      if (sclk && !prev_sclk) begin
        cur_word = {cur_word[14:0], sdo};
        cur_rises++;
      end
    end else if (csb === 1'b1 && !prev_csb) begin
      word_q.push_back(cur_word);
      low_q.push_back(cur_low);
      rise_q.push_back(cur_rises);
    end
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      busy_q.push_back(busy_run);
      busy_run = 0;
    end
    if (prev_sclk && sclk && (sdo !== prev_sdo)) mode_err++;
    prev_csb  = (csb === 1'b0) ? 1'b0 : 1'b1;
    prev_sclk = (sclk === 1'b1);
    prev_sdo  = sdo;
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [4:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (word_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (word_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", word_q.size(), n);
    end
  endtask

  task automatic wait_busy_runs(input int n, input int budget);
    int k = 0;
    while (busy_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (busy_q.size() < n) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: got %0d busy runs expected %0d", busy_q.size(), n);
    end
  endtask

  task automatic wait_csb_low(input int budget);
    int k = 0;
    while (csb !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    if (csb !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL csb_timeout: csb got %b expected 0", csb);
    end
  endtask

  // scoreboard
  logic [15:0] exp_q[$];

  task automatic compare_frames(input int n);
    for (int i = 0; i < n; i++) begin
      if (word_q.size() > 0 && exp_q.size() > 0) begin
        check("frame_word", word_q.pop_front(), exp_q.pop_front());
        check("frame_csb_low_cycles", low_q.pop_front(), 66);
        check("frame_sclk_rises", rise_q.pop_front(), 16);
      end else begin
        checks++;
        failures++;
        $display("FAIL frame_missing: got %0d frames expected %0d more", word_q.size(), n - i);
      end
    end
  endtask

  task automatic clear_monitor();
    word_q.delete();
    low_q.delete();
    rise_q.delete();
    busy_q.delete();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [4:0]  data;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{addr: 2'd1, data: 5'h05, word: 16'h3105};  // +5
    vecs[1] = '{addr: 2'd3, data: 5'h18, word: 16'h33F8};  // -8
    vecs[2] = '{addr: 2'd0, data: 5'h00, word: 16'h3000};  // 0
    vecs[3] = '{addr: 2'd2, data: 5'h0F, word: 16'h320F};  // +15
    vecs[4] = '{addr: 2'd2, data: 5'h10, word: 16'h32F0};  // -16
    vecs[5] = '{addr: 2'd0, data: 5'h1F, word: 16'h30FF};  // -1

    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;

    // reset held, then idle
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_outputs", {csb, sclk, sdo, busy, overrun}, 5'b10000);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outputs", {csb, sclk, sdo, busy, overrun}, 5'b10000);
    end
    check("idle_no_frames", word_q.size(), 0);

    // single writes from the vector table
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].word);
      write(vecs[v].addr, vecs[v].data);
      wait_frames(1, 300);
      wait_busy_runs(1, 300);
      compare_frames(1);
      if (busy_q.size() > 0) check("busy_cycles", busy_q.pop_front(), 68);
      check("idle_after_frame", {csb, sclk, busy}, 3'b100);
      step();
    end

    // burst to all channels, then round-robin wrap during the last frame
    clear_monitor();
    exp_q.push_back(16'h3001);
    exp_q.push_back(16'h3102);
    exp_q.push_back(16'h3203);
    exp_q.push_back(16'h3304);
    write(2'd0, 5'h01);
    write(2'd1, 5'h02);
    write(2'd2, 5'h03);
    write(2'd3, 5'h04);
    wait_frames(3, 1000);
    wait_csb_low(50);
    write(2'd2, 5'h1D);  // -3
    write(2'd1, 5'h09);  // +9
    exp_q.push_back(16'h3109);
    exp_q.push_back(16'h32FD);
    wait_frames(6, 1000);
    compare_frames(6);
    repeat (10) step();
    check("burst_overrun_clear", overrun, 1'b0);

    // overwrite of a pending channel during a transfer
    clear_monitor();
    exp_q.push_back(16'h3301);
    write(2'd3, 5'h01);
    wait_csb_low(50);
    write(2'd0, 5'h03);
    write(2'd0, 5'h07);
    exp_q.push_back(16'h3007);
    check("overrun_set", overrun, 1'b1);
    wait_frames(2, 1000);
    compare_frames(2);
    repeat (200) step();
    check("overrun_single_frame", word_q.size(), 0);
    check("overrun_sticky", overrun, 1'b1);

    // reset in the middle of a frame
    clear_monitor();
    write(2'd1, 5'h0A);
    write(2'd2, 5'h0B);
    begin
      int k = 0;
      while (!(csb === 1'b0 && cur_rises >= 8) && k < 500) begin
        step();
        k++;
      end
      check("abort_reached_bit8", cur_rises, 8);
    end
    rst = 1'b1;
    step();
    check("abort_outputs", {csb, sclk, busy}, 3'b100);
    check("abort_overrun", overrun, 1'b0);
    rst = 1'b0;
    check("abort_partial_bits", (rise_q.size() > 0) ? rise_q[0] : -1, 8);
    clear_monitor();
    repeat (300) step();
    check("abort_no_frames", word_q.size(), 0);
    check("abort_never_busy", busy_q.size() + busy_run, 0);
    check("abort_idle_outputs", {csb, sclk, sdo, busy, overrun}, 5'b10000);

    check("mode0_sdo_stable_when_sclk_high", mode_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
